// File: rtl/box_mean_stream.sv
// Streaming WIN x WIN box-mean filter over a raster pixel stream (crop mode).
// Emits one round-half-up mean per fully covered window, tagged with the window centre.
module box_mean_stream #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned WIN          = 9,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LAT          = 3,
    localparam int unsigned COL_W       = $clog2(IMAGE_WIDTH),
    localparam int unsigned ROW_W       = $clog2(IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gray_valid,
    input  logic [DATA_W-1:0] gray,
    input  logic              sof,
    output logic              mean_valid,
    output logic [DATA_W-1:0] mean_out,
    output logic [ROW_W-1:0]  center_row,
    output logic [COL_W-1:0]  center_col,
    output logic              mean_eof
);

    localparam int unsigned AREA   = WIN * WIN;
    localparam int unsigned SUM_W  = DATA_W + $clog2(AREA);
    localparam int unsigned CS_W   = DATA_W + $clog2(WIN);
    localparam int unsigned HALF   = (WIN - 1) / 2;
    localparam int unsigned NLB    = WIN - 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN - 1);

    logic [COL_W-1:0]  r_in_col;
    logic [ROW_W-1:0]  r_in_row;
    logic [DATA_W-1:0] r_lb [NLB][IMAGE_WIDTH];
    logic [CS_W-1:0]   r_hist [WIN];
    logic [SUM_W-1:0]  r_acc;
    logic [SUM_W-1:0]  r_sum2;
    logic [DATA_W-1:0] r_mean3;

    logic              r_pv   [LAT];
    logic [ROW_W-1:0]  r_prow [LAT];
    logic [COL_W-1:0]  r_pcol [LAT];
    logic              r_peof [LAT];

    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [CS_W-1:0]   w_col_sum;
    logic [SUM_W-1:0]  w_acc_next;
    logic              w_complete;
    logic              w_last_pix;

    // sof overrides the counters so the qualified pixel is always (0,0)
    assign w_col      = sof ? '0 : r_in_col;
    assign w_row      = sof ? '0 : r_in_row;
    assign w_complete = gray_valid && (w_row >= ROW_MIN) && (w_col >= COL_MIN);
    assign w_last_pix = (w_row == ROW_LAST) && (w_col == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_col <= '0;
            r_in_row <= '0;
        end else if (gray_valid) begin
            if (w_col == COL_LAST) begin
                r_in_col <= '0;
                r_in_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_in_col <= w_col + 1'b1;
                r_in_row <= w_row;
            end
        end
    end

    // Line buffers form a per-column shift chain: r_lb[0] holds the previous line.
    // Contents are never reset; the row count keeps stale lines out of any output.
    always_ff @(posedge clk) begin
        if (gray_valid) begin
            r_lb[0][w_col] <= gray;
            for (int k = 1; k < int'(NLB); k++) begin
                r_lb[k][w_col] <= r_lb[k-1][w_col];
            end
        end
    end

    always_comb begin
        w_col_sum = CS_W'(gray);
        for (int k = 0; k < int'(NLB); k++) begin
            w_col_sum = w_col_sum + CS_W'(r_lb[k][w_col]);
        end
    end

    // Running horizontal sum restarts at column 0 so windows never span two lines
    assign w_acc_next = (w_col == '0) ? SUM_W'(w_col_sum)
                      : r_acc + SUM_W'(w_col_sum) - SUM_W'(r_hist[WIN-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            for (int i = 0; i < int'(WIN); i++) begin
                r_hist[i] <= '0;
            end
        end else if (gray_valid) begin
            r_acc     <= w_acc_next;
            r_hist[0] <= w_col_sum;
            for (int i = 1; i < int'(WIN); i++) begin
                r_hist[i] <= (w_col == '0) ? '0 : r_hist[i-1];
            end
        end
    end

    // Free-running result pipe: sum at the beat edge, round, divide, output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum2  <= '0;
            r_mean3 <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                r_pv[i]   <= 1'b0;
                r_prow[i] <= '0;
                r_pcol[i] <= '0;
                r_peof[i] <= 1'b0;
            end
        end else begin
            r_sum2  <= r_acc + SUM_W'(AREA / 2);
            r_mean3 <= DATA_W'(r_sum2 / SUM_W'(AREA));
            r_pv[0] <= w_complete;
            if (w_complete) begin
                r_prow[0] <= w_row - ROW_W'(HALF);
                r_pcol[0] <= w_col - COL_W'(HALF);
                r_peof[0] <= w_last_pix;
            end
            for (int i = 1; i < int'(LAT); i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_prow[i] <= r_prow[i-1];
                r_pcol[i] <= r_pcol[i-1];
                r_peof[i] <= r_peof[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_valid <= 1'b0;
            mean_out   <= '0;
            center_row <= '0;
            center_col <= '0;
            mean_eof   <= 1'b0;
        end else begin
            mean_valid <= r_pv[LAT-1];
            mean_out   <= r_mean3;
            center_row <= r_prow[LAT-1];
            center_col <= r_pcol[LAT-1];
            mean_eof   <= r_pv[LAT-1] && r_peof[LAT-1];
        end
    end

endmodule
